// File: rtl/pdl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pdl_pkg
// Purpose : Shared definitions for the PDL buffer controller: default widths,
//           the operation-code encoding and the default overflow threshold.
// Rev     : 1.0  initial release
// ============================================================================
package pdl_pkg;

  localparam int PDL_ADDR_W = 10;
  localparam int PDL_DATA_W = 32;

  // Pointer value at which a PUSH raises the overflow trap
  localparam logic [PDL_ADDR_W-1:0] PDL_HIGH_WATER = 10'h3F0;

  // Operation codes carried on the op input
  localparam logic [2:0] PDL_OP_NOP    = 3'd0;
  localparam logic [2:0] PDL_OP_PUSH   = 3'd1;
  localparam logic [2:0] PDL_OP_POP    = 3'd2;
  localparam logic [2:0] PDL_OP_RD_PTR = 3'd3;
  localparam logic [2:0] PDL_OP_RD_IDX = 3'd4;
  localparam logic [2:0] PDL_OP_WR_IDX = 3'd5;
  localparam logic [2:0] PDL_OP_LD_PTR = 3'd6;
  localparam logic [2:0] PDL_OP_LD_IDX = 3'd7;

endpackage
`default_nettype wire

// File: rtl/pdl_ptr_unit.sv
`default_nettype none
// ============================================================================
// Module  : pdl_ptr_unit
// Purpose : PDL pointer and index registers (load / increment / decrement)
//           plus the decode that selects the RAM address and read/write
//           request for the operation being accepted this cycle.
// Rev     : 1.0  initial release
// ============================================================================
module pdl_ptr_unit
  import pdl_pkg::*;
#(
  parameter int ADDR_W = PDL_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] ld_val,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] acc_addr,
  output logic              rd_req,
  output logic              wr_req
);

  logic [ADDR_W-1:0] ptr_d, ptr_q;
  logic [ADDR_W-1:0] idx_d, idx_q;

  // Decode the accepted op: new ptr/idx, access address and strobe request.
  // All address arithmetic uses the pre-op register values and wraps.
  always_comb begin
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    acc_addr = ptr_q;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    if (op_valid) begin
      case (op)
        PDL_OP_PUSH: begin
          ptr_d    = ptr_q + ADDR_W'(1);
          acc_addr = ptr_q + ADDR_W'(1);
          wr_req   = 1'b1;
        end
        PDL_OP_POP: begin
          acc_addr = ptr_q;
          rd_req   = 1'b1;
          ptr_d    = ptr_q - ADDR_W'(1);
        end
        PDL_OP_RD_PTR: begin
          acc_addr = ptr_q;
          rd_req   = 1'b1;
        end
        PDL_OP_RD_IDX: begin
          acc_addr = idx_q;
          rd_req   = 1'b1;
        end
        PDL_OP_WR_IDX: begin
          acc_addr = idx_q;
          wr_req   = 1'b1;
        end
        PDL_OP_LD_PTR: ptr_d = ld_val;
        PDL_OP_LD_IDX: idx_d = ld_val;
        default: ;
      endcase
    end
  end

  // Pointer and index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      idx_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      idx_q <= idx_d;
    end
  end

  assign ptr = ptr_q;
  assign idx = idx_q;

endmodule
`default_nettype wire

// File: rtl/pdl_ctl.sv
`default_nettype none
// ============================================================================
// Module  : pdl_ctl
// Purpose : Initiator side of the 1K x 32 PDL buffer RAM. Registers the RAM
//           address / strobes / write data, tracks read-data validity and
//           optionally raises overflow/underflow trap pulses.
// Config  : define PDL_BOUNDS_TRAP_EN to build the ovf/unf comparators;
//           otherwise ovf and unf are constant 0.
// Rev     : 1.0  initial release
// ============================================================================
module pdl_ctl
  import pdl_pkg::*;
#(
  parameter int                ADDR_W     = PDL_ADDR_W,
  parameter int                DATA_W     = PDL_DATA_W,
  parameter logic [ADDR_W-1:0] HIGH_WATER = PDL_HIGH_WATER
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] l,
  input  logic [ADDR_W-1:0] ld_val,
  output logic [ADDR_W-1:0] pdla,
  output logic              prp,
  output logic              pwp,
  output logic [DATA_W-1:0] pdl_wdata,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] pdlptr,
  output logic [ADDR_W-1:0] pdlidx,
  output logic              ovf,
  output logic              unf
);

  logic [ADDR_W-1:0] acc_addr;
  logic              rd_req;
  logic              wr_req;

  logic [ADDR_W-1:0] pdla_d, pdla_q;
  logic              prp_d, prp_q;
  logic              pwp_d, pwp_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              rd_valid_d, rd_valid_q;

  pdl_ptr_unit #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_valid (op_valid),
    .op       (op),
    .ld_val   (ld_val),
    .ptr      (pdlptr),
    .idx      (pdlidx),
    .acc_addr (acc_addr),
    .rd_req   (rd_req),
    .wr_req   (wr_req)
  );

  // Strobe pipeline: address and write data are captured only when a
  // strobe fires, so they hold between accesses; rd_valid trails prp by one
  // cycle to match the RAM's synchronous read.
  always_comb begin
    prp_d      = rd_req;
    pwp_d      = wr_req;
    pdla_d     = (rd_req || wr_req) ? acc_addr : pdla_q;
    wdata_d    = wr_req ? l : wdata_q;
    rd_valid_d = prp_q;
  end

  // Registered RAM interface
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pdla_q     <= '0;
      prp_q      <= 1'b0;
      pwp_q      <= 1'b0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      pdla_q     <= pdla_d;
      prp_q      <= prp_d;
      pwp_q      <= pwp_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign pdla      = pdla_q;
  assign prp       = prp_q;
  assign pwp       = pwp_q;
  assign pdl_wdata = wdata_q;
  assign rd_valid  = rd_valid_q;

`ifdef PDL_BOUNDS_TRAP_EN
  logic ovf_d, ovf_q;
  logic unf_d, unf_q;

  // Trap detection against the pre-op pointer; the op itself still executes
  always_comb begin
    ovf_d = op_valid && (op == PDL_OP_PUSH) && (pdlptr == HIGH_WATER);
    unf_d = op_valid && (op == PDL_OP_POP)  && (pdlptr == '0);
  end

  // Single-cycle trap pulses aligned with the strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  // Threshold has no consumer when traps are not built
  logic unused_high_water;
  assign unused_high_water = ^HIGH_WATER;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pdl_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pdl_ctl
// Purpose : Self-checking bench for pdl_ctl with a behavioural stack/RAM
//           reference model and a bench-side RAM fed by the DUT strobes.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pdl_ctl;
  import pdl_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [DW-1:0] l = '0;
  logic [AW-1:0] ld_val = '0;

  logic [AW-1:0] pdla;
  logic          prp, pwp;
  logic [DW-1:0] pdl_wdata;
  logic          rd_valid;
  logic [AW-1:0] pdlptr, pdlidx;
  logic          ovf, unf;

  pdl_ctl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_valid  (op_valid),
    .op        (op),
    .l         (l),
    .ld_val    (ld_val),
    .pdla      (pdla),
    .prp       (prp),
    .pwp       (pwp),
    .pdl_wdata (pdl_wdata),
    .rd_valid  (rd_valid),
    .pdlptr    (pdlptr),
    .pdlidx    (pdlidx),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  // Bench-side RAM driven by the DUT's strobes (1-cycle synchronous read)
  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (pwp) ram[pdla] <= pdl_wdata;
    if (prp) ram_q <= ram[pdla];
  end

  int checks = 0;
  int failures = 0;

  // Reference model: stack contents, pointers and expected interface state
  logic [AW-1:0] m_ptr, m_idx, m_pdla;
  logic [DW-1:0] m_wdata, m_pend, m_rdata;
  logic [DW-1:0] m_mem [0:1023];
  logic          m_prp, m_pwp, m_rdv, m_ovf, m_unf;

  task automatic model_reset();
    m_ptr = '0; m_idx = '0; m_pdla = '0; m_wdata = '0;
    m_pend = '0; m_rdata = '0;
    m_prp = 1'b0; m_pwp = 1'b0; m_rdv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Apply one op for one cycle, advance the model, compare every output
  task automatic run_op(input logic v, input logic [2:0] o,
                        input logic [DW-1:0] d, input logic [AW-1:0] ld);
    op_valid = v; op = o; l = d; ld_val = ld;
    m_rdv = m_prp; m_rdata = m_pend;
    m_prp = 1'b0; m_pwp = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    if (v) begin
      case (o)
        PDL_OP_PUSH: begin
          m_ovf = (m_ptr == 10'h3F0);
          m_ptr = m_ptr + 10'd1;
          m_pdla = m_ptr; m_pwp = 1'b1; m_wdata = d; m_mem[m_ptr] = d;
        end
        PDL_OP_POP: begin
          m_unf = (m_ptr == 10'd0);
          m_pdla = m_ptr; m_prp = 1'b1; m_pend = m_mem[m_ptr];
          m_ptr = m_ptr - 10'd1;
        end
        PDL_OP_RD_PTR: begin m_pdla = m_ptr; m_prp = 1'b1; m_pend = m_mem[m_ptr]; end
        PDL_OP_RD_IDX: begin m_pdla = m_idx; m_prp = 1'b1; m_pend = m_mem[m_idx]; end
        PDL_OP_WR_IDX: begin
          m_pdla = m_idx; m_pwp = 1'b1; m_wdata = d; m_mem[m_idx] = d;
        end
        PDL_OP_LD_PTR: m_ptr = ld;
        PDL_OP_LD_IDX: m_idx = ld;
        default: ;
      endcase
    end
`ifndef PDL_BOUNDS_TRAP_EN
    m_ovf = 1'b0; m_unf = 1'b0;
`endif
    @(posedge clk); #1;
    checks++; if (pdla !== m_pdla) begin failures++; $display("FAIL pdla: got %h expected %h (op %0d)", pdla, m_pdla, o); end
    checks++; if (prp !== m_prp) begin failures++; $display("FAIL prp: got %b expected %b (op %0d)", prp, m_prp, o); end
    checks++; if (pwp !== m_pwp) begin failures++; $display("FAIL pwp: got %b expected %b (op %0d)", pwp, m_pwp, o); end
    checks++; if (pdl_wdata !== m_wdata) begin failures++; $display("FAIL pdl_wdata: got %h expected %h", pdl_wdata, m_wdata); end
    checks++; if (pdlptr !== m_ptr) begin failures++; $display("FAIL pdlptr: got %h expected %h", pdlptr, m_ptr); end
    checks++; if (pdlidx !== m_idx) begin failures++; $display("FAIL pdlidx: got %h expected %h", pdlidx, m_idx); end
    checks++; if (rd_valid !== m_rdv) begin failures++; $display("FAIL rd_valid: got %b expected %b", rd_valid, m_rdv); end
    checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL ovf: got %b expected %b", ovf, m_ovf); end
    checks++; if (unf !== m_unf) begin failures++; $display("FAIL unf: got %b expected %b", unf, m_unf); end
    if (m_rdv) begin
      checks++; if (ram_q !== m_rdata) begin failures++; $display("FAIL rdata: got %h expected %h", ram_q, m_rdata); end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1; op = 3'($urandom_range(0, 7));
      l = $urandom; ld_val = 10'($urandom);
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    reset_n = 1'b1;
    checks++; if ({pdla, prp, pwp, pdl_wdata, rd_valid, pdlptr, pdlidx, ovf, unf} !== '0) begin
      failures++; $display("FAIL reset_outputs: got pdla=%h prp=%b pwp=%b wd=%h rdv=%b ptr=%h idx=%h ovf=%b unf=%b expected all 0",
                           pdla, prp, pwp, pdl_wdata, rd_valid, pdlptr, pdlidx, ovf, unf);
    end
    model_reset();
    run_op(1'b0, PDL_OP_NOP, '0, '0);
  endtask

  task automatic test_first_push();
    run_op(1'b1, PDL_OP_PUSH, 32'hDEADBEEF, '0);
    checks++; if ({pwp, pdla, pdl_wdata, pdlptr} !== {1'b1, 10'd1, 32'hDEADBEEF, 10'd1}) begin
      failures++; $display("FAIL first_push: got pwp=%b pdla=%h wd=%h ptr=%h expected 1/001/deadbeef/001", pwp, pdla, pdl_wdata, pdlptr);
    end
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, PDL_OP_LD_PTR, '0, 10'd0);
    run_op(1'b1, PDL_OP_PUSH, 32'hAAAA0001, '0);
    run_op(1'b1, PDL_OP_PUSH, 32'hBBBB0002, '0);
    run_op(1'b1, PDL_OP_POP, '0, '0);
    checks++; if (pdla !== 10'd2 || prp !== 1'b1) begin failures++; $display("FAIL b2b_pop1_addr: got %h expected 002", pdla); end
    run_op(1'b1, PDL_OP_POP, '0, '0);
    checks++; if (pdla !== 10'd1 || ram_q !== 32'hBBBB0002 || rd_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_pop1_data: got addr=%h q=%h expected 001 bbbb0002", pdla, ram_q);
    end
    run_op(1'b0, PDL_OP_NOP, '0, '0);
    checks++; if (ram_q !== 32'hAAAA0001 || rd_valid !== 1'b1 || pdlptr !== 10'd0) begin
      failures++; $display("FAIL b2b_pop2_data: got q=%h ptr=%h expected aaaa0001 000", ram_q, pdlptr);
    end
    run_op(1'b0, PDL_OP_NOP, '0, '0);
  endtask

  task automatic test_index();
    logic [AW-1:0] ptr_before;
    ptr_before = m_ptr;
    run_op(1'b1, PDL_OP_LD_IDX, '0, 10'h155);
    run_op(1'b1, PDL_OP_WR_IDX, 32'h12345678, '0);
    checks++; if (pwp !== 1'b1 || pdla !== 10'h155) begin failures++; $display("FAIL idx_write: got pwp=%b pdla=%h expected 1 155", pwp, pdla); end
    run_op(1'b1, PDL_OP_RD_IDX, '0, '0);
    checks++; if (prp !== 1'b1 || pdla !== 10'h155) begin failures++; $display("FAIL idx_read: got prp=%b pdla=%h expected 1 155", prp, pdla); end
    run_op(1'b0, PDL_OP_NOP, '0, '0);
    checks++; if (ram_q !== 32'h12345678 || pdlptr !== ptr_before) begin
      failures++; $display("FAIL idx_data: got q=%h ptr=%h expected 12345678 %h", ram_q, pdlptr, ptr_before);
    end
  endtask

  task automatic test_wrap();
    run_op(1'b1, PDL_OP_LD_PTR, '0, 10'h3FF);
    run_op(1'b1, PDL_OP_PUSH, 32'hC0FFEE00, '0);
    checks++; if (pdla !== 10'd0 || pdlptr !== 10'd0) begin failures++; $display("FAIL wrap_push: got pdla=%h ptr=%h expected 000 000", pdla, pdlptr); end
    run_op(1'b1, PDL_OP_POP, '0, '0);
    checks++; if (pdla !== 10'd0 || pdlptr !== 10'h3FF) begin failures++; $display("FAIL wrap_pop: got pdla=%h ptr=%h expected 000 3ff", pdla, pdlptr); end
    run_op(1'b0, PDL_OP_NOP, '0, '0);
  endtask

  task automatic test_traps();
    run_op(1'b1, PDL_OP_LD_PTR, '0, 10'h3F0);
    run_op(1'b1, PDL_OP_PUSH, 32'h0F0F0F0F, '0);
    checks++; if (pdlptr !== 10'h3F1) begin failures++; $display("FAIL trap_push_ptr: got %h expected 3f1", pdlptr); end
    run_op(1'b0, PDL_OP_NOP, '0, '0);
    run_op(1'b1, PDL_OP_LD_PTR, '0, 10'd0);
    run_op(1'b1, PDL_OP_POP, '0, '0);
    run_op(1'b0, PDL_OP_NOP, '0, '0);
    run_op(1'b0, PDL_OP_NOP, '0, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run_op(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
             (i % 7 == 0) ? 10'($urandom_range(1012, 1023)) : 10'($urandom_range(0, 12)));
    end
    run_op(1'b0, PDL_OP_NOP, '0, '0);
    run_op(1'b0, PDL_OP_NOP, '0, '0);
  endtask

  task automatic test_reset_after_pop();
    run_op(1'b1, PDL_OP_LD_PTR, '0, 10'd5);
    run_op(1'b1, PDL_OP_POP, '0, '0);
    op_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_valid !== 1'b0 || pdlptr !== 10'd0) begin
        failures++; $display("FAIL reset_drop_read: got rdv=%b ptr=%h expected 0 000", rd_valid, pdlptr);
      end
      @(posedge clk); #1;
    end
    run_op(1'b0, PDL_OP_NOP, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0;
      m_mem[i] = '0;
    end
    model_reset();
    #1;
    test_reset();
    test_first_push();
    test_back_to_back();
    test_index();
    test_wrap();
    test_traps();
    test_random();
    test_reset_after_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
